led_pulse_stretcher: RTL and testbench
======================================

// Module: led_pulse_stretcher
// PURPOSE
//  Output-side companion to the input debouncer: turns fast internal events into human-visible LED blinks.
//  Each accepted event yields one high pulse of exactly ON_CKS cycles, then a dark gap of OFF_CKS cycles.
//  Sits between core logic (or a debounced switch) and a board LED pin; one instance per LED.
// PARAMETERS
//  ON_CKS    250000  LED-on cycles per blink, >=1
//  OFF_CKS   250000  mandatory dark cycles after each blink, >=1
//  PEND_MAX  15      saturation limit of pending-event count, >=1 (used only with LED_PULSE_QUEUE_EN)
// PORTS
//  i_Clk      in   1   single clock; all logic on posedge
//  i_Rst      in   1   reset, synchronous, active-high
//  i_Event    in   1   event input; level or strobe; each rising edge is one event
//  o_Led      out  1   registered LED drive, high during ON
//  o_Busy     out  1   high in ON or GAP state
//  o_Pending  out  PW  events waiting; PW=$clog2(PEND_MAX+1); constant 0 without LED_PULSE_QUEUE_EN
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, o_Led=0, o_Busy=0, o_Pending=0, effective the edge after i_Rst=1.
//  r_Evt_d <= i_Event every cycle, including during reset: a level held through reset release is NOT an event.
//  Event accepted on a cycle with i_Event=1 && r_Evt_d=0 && !i_Rst.
//  Counter width $clog2(max(ON_CKS,OFF_CKS)+1); cleared on every state change; no wrap (bounded by terminal compare).
//  FSM:
//   IDLE: accepted event -> ON at the next edge; o_Led=1 on the cycle after the accepting cycle (latency 1).
//   ON:   cnt counts 0..ON_CKS-1; at cnt==ON_CKS-1 -> GAP. o_Led high for exactly ON_CKS cycles.
//   GAP:  o_Led=0; cnt counts 0..OFF_CKS-1; at terminal: pending>0 -> ON and pending-1; else -> IDLE.
//  o_Busy = (state!=IDLE), registered together with the state.
//  Events in ON/GAP: with the feature, pending+1, saturating at PEND_MAX (extra events dropped silently).
//  Same-cycle accept and decrement (event on final GAP cycle while pending>0): pending unchanged.
//  Event on the final GAP cycle with pending==0: goes to IDLE with pending=1 (with the feature), then ON on the following edge.
//  Reset mid-ON or mid-GAP: immediate abort, o_Led=0 next edge, pending lost.
// CONFIGURATION
//  LED_PULSE_QUEUE_EN defined: pending counter active; every event (up to PEND_MAX queued) produces its own blink.
//  Not defined: no counter; events during ON/GAP are ignored (no retrigger, no extension); o_Pending tied 0.
// STRUCTURE
//  Package led_pulse_pkg: state encoding localparams ST_IDLE=2'd0, ST_ON=2'd1, ST_GAP=2'd2; width helper.
//  Sub-module rise_detect (i_Clk, i_Sig, o_Rise): holds r_Evt_d, no reset dependence; reusable.
//  Top: FSM, counter, optional pending counter in one always block per register group.
// TESTING (ON_CKS=4, OFF_CKS=3, PEND_MAX=2 unless stated)
//  1 Single 1-cycle i_Event at cycle 10 -> o_Led=1 cycles 11-14, 0 cycles 15-17; o_Busy=1 cycles 11-17; IDLE at 18.
//  2 i_Event held high 20 cycles from cycle 10 -> exactly one blink (cycles 11-14), o_Pending stays 0.
//  3 Three strobes during ON, feature on -> o_Pending saturates at 2; two further blinks, each followed by a 3-cycle gap.
//    Feature off -> one blink only, o_Pending=0.
//  4 Pending=1, strobe on final GAP cycle -> o_Pending stays 1, ON re-entered immediately; total two further blinks.
//  5 i_Rst pulsed during ON cycle 2 with i_Event held high across release -> o_Led=0, o_Busy=0, o_Pending=0 next edge; no blink after release.
//  6 ON_CKS=1, OFF_CKS=1, pending=2, strobes stopped -> o_Led pattern 1,0,1,0,1,0 then IDLE.

Source files
------------

// File: rtl/led_pulse_pkg.sv
// Shared definitions for the LED pulse stretcher: state encoding and width helpers.
// Optional feature macro used by the top: LED_PULSE_QUEUE_EN (pending-event queue).
package led_pulse_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ON   = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    // Phase counter width: wide enough to hold the longer of the two phase lengths.
    function automatic int f_cnt_width(input int on_cks, input int off_cks);
        int m;
        m = (on_cks > off_cks) ? on_cks : off_cks;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    // Pending-count width for a saturation limit of pend_max.
    function automatic int f_pend_width(input int pend_max);
        return (pend_max < 1) ? 1 : $clog2(pend_max + 1);
    endfunction

endpackage

// File: rtl/led_pulse_stretcher_if.sv
// Signal bundle for one LED pulse stretcher: event input, LED drive, busy flag and pending count.
// master = event source / observer, slave = stretcher side.
interface led_pulse_stretcher_if #(
    parameter int PW = 2
);
    logic          Event;
    logic          Led;
    logic          Busy;
    logic [PW-1:0] Pending;

    modport master (output Event, input Led, input Busy, input Pending);
    modport slave  (input Event, output Led, output Busy, output Pending);
endinterface

// File: rtl/led_pulse_stretcher_rise_detect.sv
// Rising-edge detector. The delayed copy runs every cycle with no reset, so a level that is
// already high when a surrounding reset is released does not look like a fresh edge.
module rise_detect (
    input  logic i_Clk,
    input  logic i_Sig,
    output logic o_Rise
);
    logic r_Evt_d;

    // Delay the input by one cycle, unconditionally.
    always_ff @(posedge i_Clk) begin
        r_Evt_d <= i_Sig;
    end

    assign o_Rise = i_Sig & ~r_Evt_d;
endmodule

// File: rtl/led_pulse_stretcher.sv
// LED pulse stretcher: each accepted rising edge on i_Event becomes one LED-on pulse of
// ON_CKS cycles followed by a dark gap of OFF_CKS cycles.
// Define LED_PULSE_QUEUE_EN to queue events that arrive while busy (up to PEND_MAX); without it
// such events are dropped and o_Pending is tied to zero.
module led_pulse_stretcher
    import led_pulse_pkg::*;
#(
    parameter int ON_CKS   = 250000,
    parameter int OFF_CKS  = 250000,
    parameter int PEND_MAX = 15
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_Event,
    output logic                          o_Led,
    output logic                          o_Busy,
    output logic [$clog2(PEND_MAX+1)-1:0] o_Pending
);
    localparam int CW = f_cnt_width(ON_CKS, OFF_CKS);
    localparam int PW = $clog2(PEND_MAX + 1);

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CKS - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CKS - 1);

    logic          w_Rise;
    logic          w_Accept;
    state_t        r_State;
    state_t        w_State_Next;
    logic [CW-1:0] r_Cnt;
    logic          r_Led;
    logic          r_Busy;
    logic          w_Led_Next;
    logic          w_Busy_Next;
    logic          w_On_End;
    logic          w_Gap_End;
    logic          w_Pend_Nz;

    rise_detect u_rise_detect (
        .i_Clk  (i_Clk),
        .i_Sig  (i_Event),
        .o_Rise (w_Rise)
    );

    // An edge seen while reset is asserted is discarded rather than remembered.
    assign w_Accept  = w_Rise & ~i_Rst;
    assign w_On_End  = (r_State == ST_ON)  && (r_Cnt == ON_LAST);
    assign w_Gap_End = (r_State == ST_GAP) && (r_Cnt == OFF_LAST);

`ifdef LED_PULSE_QUEUE_EN
    logic [PW-1:0] r_Pend;
    logic          w_Inc;
    logic          w_Dec;

    assign w_Pend_Nz = (r_Pend != '0);
    // Every accepted event queues, except one that directly launches a blink from an empty IDLE.
    assign w_Inc = w_Accept && !((r_State == ST_IDLE) && !w_Pend_Nz);
    // A queued event is consumed whenever a blink is launched from the queue.
    assign w_Dec = w_Pend_Nz && ((r_State == ST_IDLE) || w_Gap_End);

    // Pending counter: saturating increment, decrement on launch, net zero when both coincide.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Pend <= '0;
        end else if (w_Inc && !w_Dec) begin
            if (r_Pend != PW'(PEND_MAX)) begin
                r_Pend <= r_Pend + 1'b1;
            end
        end else if (!w_Inc && w_Dec) begin
            r_Pend <= r_Pend - 1'b1;
        end
    end

    assign o_Pending = r_Pend;
`else
    assign w_Pend_Nz = 1'b0;
    assign o_Pending = '0;
`endif

    // Next-state decision for the IDLE -> ON -> GAP cycle.
    always_comb begin
        w_State_Next = r_State;
        case (r_State)
            ST_IDLE: begin
                if (w_Accept || w_Pend_Nz) begin
                    w_State_Next = ST_ON;
                end
            end
            ST_ON: begin
                if (w_On_End) begin
                    w_State_Next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_Gap_End) begin
                    w_State_Next = w_Pend_Nz ? ST_ON : ST_IDLE;
                end
            end
            default: begin
                w_State_Next = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so LED and busy are registered alongside it.
    always_comb begin
        w_Led_Next  = (w_State_Next == ST_ON);
        w_Busy_Next = (w_State_Next != ST_IDLE);
    end

    // State register with registered LED and busy outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State <= ST_IDLE;
            r_Led   <= 1'b0;
            r_Busy  <= 1'b0;
        end else begin
            r_State <= w_State_Next;
            r_Led   <= w_Led_Next;
            r_Busy  <= w_Busy_Next;
        end
    end

    // Phase counter: restarts on every state change, never runs past the terminal compare.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Cnt <= '0;
        end else if ((w_State_Next != r_State) || (r_State == ST_IDLE)) begin
            r_Cnt <= '0;
        end else begin
            r_Cnt <= r_Cnt + 1'b1;
        end
    end

    assign o_Led  = r_Led;
    assign o_Busy = r_Busy;
endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Self-checking bench for led_pulse_stretcher: two instances (ON=4/OFF=3 and ON=1/OFF=1,
// both PEND_MAX=2), table vectors, hand-written corner sequences and a random run compared
// every cycle against a blink-window reference model.
module tb_led_pulse_stretcher;

`ifdef LED_PULSE_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

    localparam int A_ON = 4, A_OFF = 3, B_ON = 1, B_OFF = 1, PMAX = 2;

    logic clk;
    logic rst_a;
    logic rst_b;

    led_pulse_stretcher_if #(.PW(2)) if_a ();
    led_pulse_stretcher_if #(.PW(2)) if_b ();

    led_pulse_stretcher #(.ON_CKS(A_ON), .OFF_CKS(A_OFF), .PEND_MAX(PMAX)) dut_a (
        .i_Clk     (clk),
        .i_Rst     (rst_a),
        .i_Event   (if_a.Event),
        .o_Led     (if_a.Led),
        .o_Busy    (if_a.Busy),
        .o_Pending (if_a.Pending)
    );

    led_pulse_stretcher #(.ON_CKS(B_ON), .OFF_CKS(B_OFF), .PEND_MAX(PMAX)) dut_b (
        .i_Clk     (clk),
        .i_Rst     (rst_b),
        .i_Event   (if_b.Event),
        .o_Led     (if_b.Led),
        .o_Busy    (if_b.Busy),
        .o_Pending (if_b.Pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit ev;
        bit led;
        bit busy;
        int pend;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state: cycles left in the current blink window (ON+OFF long, 0 = idle),
    // pending events, and the previous event level.
    int ma_left = 0, ma_pend = 0, mb_left = 0, mb_pend = 0;
    bit ma_prev = 1'b0, mb_prev = 1'b0;

    int a_blinks = 0, b_blinks = 0, a_high = 0;
    bit a_led_prev = 1'b0, b_led_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    // One clock edge of the behavioural model.
    task automatic model_step(input int on_c, input int off_c, input int pmax,
                              input bit ev, input bit rst,
                              inout int left, inout int pend, inout bit prev);
        bit rise;
        rise = ev && !prev && !rst;
        prev = ev;
        if (rst) begin
            left = 0;
            pend = 0;
        end else if (!QUEUE_EN) begin
            if (left > 0) left--;
            else if (rise) left = on_c + off_c;
        end else if (left == 0) begin
            if (rise || pend > 0) begin
                left = on_c + off_c;
                if (pend > 0) pend = pend - 1 + int'(rise);
            end
        end else if (left == 1) begin
            if (pend > 0) begin
                left = on_c + off_c;
                pend = pend - 1 + int'(rise);
            end else begin
                left = 0;
                pend = int'(rise);
            end
        end else begin
            left--;
            if (rise && pend < pmax) pend++;
        end
    endtask

    // Advance one cycle: update models, clock, then compare both instances.
    task automatic tick();
        model_step(A_ON, A_OFF, PMAX, if_a.Event, rst_a, ma_left, ma_pend, ma_prev);
        model_step(B_ON, B_OFF, PMAX, if_b.Event, rst_b, mb_left, mb_pend, mb_prev);
        @(posedge clk);
        #1;
        cyc++;
        chk("a_led",  if_a.Led,     (ma_left > A_OFF) ? 1 : 0);
        chk("a_busy", if_a.Busy,    (ma_left > 0) ? 1 : 0);
        chk("a_pend", if_a.Pending, ma_pend);
        chk("b_led",  if_b.Led,     (mb_left > B_OFF) ? 1 : 0);
        chk("b_busy", if_b.Busy,    (mb_left > 0) ? 1 : 0);
        chk("b_pend", if_b.Pending, mb_pend);
        if (if_a.Led === 1'b1 && !a_led_prev) a_blinks++;
        if (if_b.Led === 1'b1 && !b_led_prev) b_blinks++;
        if (if_a.Led === 1'b1) a_high++;
        a_led_prev = (if_a.Led === 1'b1);
        b_led_prev = (if_b.Led === 1'b1);
    endtask

    vec_t t1[9];
    vec_t t6[10];
    int   snap;
    int   snap_h;

    initial begin
        // Single strobe: on 4 cycles, dark 3, then idle.
        for (int i = 0; i < 9; i++) begin
            t1[i] = '{ev: (i == 0), led: (i < 4), busy: (i < 7), pend: 0};
        end
        // ON=1/OFF=1 instance, strobes on alternate edges then stop.
        if (QUEUE_EN) begin
            t6[0] = '{1, 1, 1, 0};
            t6[1] = '{0, 0, 1, 0};
            t6[2] = '{1, 0, 0, 1};
            t6[3] = '{0, 1, 1, 0};
            t6[4] = '{1, 0, 1, 1};
            t6[5] = '{0, 1, 1, 0};
            t6[6] = '{0, 0, 1, 0};
            t6[7] = '{0, 0, 0, 0};
        end else begin
            t6[0] = '{1, 1, 1, 0};
            t6[1] = '{0, 0, 1, 0};
            t6[2] = '{1, 0, 0, 0};
            t6[3] = '{0, 0, 0, 0};
            t6[4] = '{1, 1, 1, 0};
            t6[5] = '{0, 0, 1, 0};
            t6[6] = '{0, 0, 0, 0};
            t6[7] = '{0, 0, 0, 0};
        end
        t6[8] = '{0, 0, 0, 0};
        t6[9] = '{0, 0, 0, 0};

        if_a.Event = 1'b0;
        if_b.Event = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) tick();
        chk("rst_led",  if_a.Led, 0);
        chk("rst_busy", if_a.Busy, 0);
        chk("rst_pend", if_a.Pending, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) tick();

        // Single strobe table.
        for (int i = 0; i < 9; i++) begin
            if_a.Event = t1[i].ev;
            tick();
            chk("t1_led",  if_a.Led,     int'(t1[i].led));
            chk("t1_busy", if_a.Busy,    int'(t1[i].busy));
            chk("t1_pend", if_a.Pending, t1[i].pend);
        end

        // Level held for 20 cycles gives exactly one blink.
        snap = a_blinks;
        for (int k = 0; k < 20; k++) begin
            if_a.Event = 1'b1;
            tick();
            chk("t2_led",  if_a.Led,  (k < 4) ? 1 : 0);
            chk("t2_busy", if_a.Busy, (k < 7) ? 1 : 0);
            chk("t2_pend", if_a.Pending, 0);
        end
        if_a.Event = 1'b0;
        repeat (3) tick();
        chk("t2_blinks", a_blinks - snap, 1);

        // Extra strobes while busy: pending saturates at PEND_MAX.
        snap = a_blinks;
        snap_h = a_high;
        for (int k = 0; k < 7; k++) begin
            if_a.Event = (k % 2 == 0);
            tick();
            if (k == 2) chk("t3_pend1", if_a.Pending, QUEUE_EN ? 1 : 0);
            if (k == 4) chk("t3_pend2", if_a.Pending, QUEUE_EN ? 2 : 0);
            if (k == 6) chk("t3_sat",   if_a.Pending, QUEUE_EN ? 2 : 0);
        end
        if_a.Event = 1'b0;
        repeat (40) tick();
        chk("t3_blinks", a_blinks - snap, QUEUE_EN ? 3 : 1);
        chk("t3_high",   a_high - snap_h, QUEUE_EN ? 12 : 4);

        // Pending=1 and a strobe on the final gap cycle.
        for (int k = 0; k < 7; k++) begin
            if_a.Event = (k == 0 || k == 2);
            tick();
        end
        chk("t4_pre_pend", if_a.Pending, QUEUE_EN ? 1 : 0);
        snap = a_blinks;
        if_a.Event = 1'b1;
        tick();
        chk("t4_led",  if_a.Led,     QUEUE_EN ? 1 : 0);
        chk("t4_busy", if_a.Busy,    QUEUE_EN ? 1 : 0);
        chk("t4_pend", if_a.Pending, QUEUE_EN ? 1 : 0);
        if_a.Event = 1'b0;
        repeat (30) tick();
        chk("t4_blinks", a_blinks - snap, QUEUE_EN ? 2 : 0);

        // Reset mid-blink with the event level held across release.
        for (int k = 0; k < 3; k++) begin
            if_a.Event = (k != 1);
            tick();
        end
        chk("t5_pre_pend", if_a.Pending, QUEUE_EN ? 1 : 0);
        rst_a = 1'b1;
        if_a.Event = 1'b1;
        tick();
        chk("t5_led",  if_a.Led, 0);
        chk("t5_busy", if_a.Busy, 0);
        chk("t5_pend", if_a.Pending, 0);
        rst_a = 1'b0;
        snap = a_blinks;
        repeat (10) tick();
        chk("t5_blinks", a_blinks - snap, 0);
        if_a.Event = 1'b0;
        tick();

        // ON=1/OFF=1 table.
        for (int i = 0; i < 10; i++) begin
            if_b.Event = t6[i].ev;
            tick();
            chk("t6_led",  if_b.Led,     int'(t6[i].led));
            chk("t6_busy", if_b.Busy,    int'(t6[i].busy));
            chk("t6_pend", if_b.Pending, t6[i].pend);
        end

        // Random run on both instances against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) if_a.Event = ~if_a.Event;
            if ($urandom_range(0, 2) == 0) if_b.Event = ~if_b.Event;
            rst_a = ($urandom_range(0, 149) == 0);
            rst_b = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
